aec_feeder: RTL and testbench

Upstream front end for the expression calculator. Accepts a raw ASCII byte stream over a valid/ready handshake, validates and buffers one complete infix expression terminated by `=`, then replays it to the calculator one character per cycle with a first-cycle `ready` strobe. It holds off the next expression until the calculator reports `valid`. Malformed expressions are dropped and flagged.

---
 rtl/aec_pkg.sv | 25 ++
 rtl/aec_feeder_char_class.sv | 31 +++
 rtl/aec_feeder.sv | 152 +++++++++++++++
 tb/tb_aec_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// Shared constants for the expression-calculator front end:
// ASCII codes, feeder state encoding and discard-cause codes.
package aec_pkg;

   localparam logic [7:0] CH_LPAR = 8'h28;
   localparam logic [7:0] CH_RPAR = 8'h29;
   localparam logic [7:0] CH_MUL  = 8'h2A;
   localparam logic [7:0] CH_ADD  = 8'h2B;
   localparam logic [7:0] CH_SUB  = 8'h2D;
   localparam logic [7:0] CH_EQ   = 8'h3D;
   localparam logic [7:0] CH_SP   = 8'h20;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_CHECK   = 2'd1,
      ST_SEND    = 2'd2,
      ST_WAIT    = 2'd3
   } feeder_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_PAREN    = 2'd3;

endpackage

// File: rtl/aec_feeder_char_class.sv
// Combinational ASCII classifier for the feeder.
// Ports: ch (byte in) -> is_digit/is_lpar/is_rpar/is_op/is_eq/is_space/is_illegal.
module aec_char_class
   import aec_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_digit,
   output logic       is_lpar,
   output logic       is_rpar,
   output logic       is_op,
   output logic       is_eq,
   output logic       is_space,
   output logic       is_illegal
);

   // Hex digits: 0-9 and lower-case a-f
   assign is_digit = ((ch >= 8'h30) && (ch <= 8'h39)) ||
                     ((ch >= 8'h61) && (ch <= 8'h66));
   assign is_lpar  = (ch == CH_LPAR);
   assign is_rpar  = (ch == CH_RPAR);
   assign is_op    = (ch == CH_MUL) || (ch == CH_ADD) ||
                     (ch == CH_SUB);
   assign is_eq    = (ch == CH_EQ);
   assign is_space = (ch == CH_SP);

   // Space is reported illegal here; the feeder decides
   // whether to skip it instead.
   assign is_illegal = !(is_digit || is_lpar || is_rpar ||
                         is_op || is_eq);

endmodule

// File: rtl/aec_feeder.sv
// Buffers one validated infix expression and replays it to the calculator.
// Ports: clk, rst (sync, active-high); in_valid/in_char/in_ready byte input;
// ascii_out/ready_out replay; calc_valid ends WAIT; err/err_code discard flag.
// Build option: AEC_FEEDER_SPACE_SKIP_EN makes 0x20 accepted and dropped.
module aec_feeder
   import aec_pkg::*;
#(
   parameter int MAX_LEN = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_char,
   output logic       in_ready,
   output logic [7:0] ascii_out,
   output logic       ready_out,
   input  logic       calc_valid,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int PW = $clog2(MAX_LEN + 1);
   localparam logic [PW-1:0] LAST = PW'(MAX_LEN - 1);

   feeder_state_t   state_q;
   logic [PW-1:0]   wptr_q;
   logic [PW-1:0]   rptr_q;
   logic [PW-1:0]   len_q;
   logic [PW-1:0]   rnext;
   logic [3:0]      depth_q;
   logic [7:0]      mem [MAX_LEN];

   logic is_digit, is_lpar, is_rpar, is_op;
   logic is_eq, is_space, is_illegal;
   logic acc, sp_en, skip, storable;
   logic e_ill, e_ovf, e_rpar, wr_en;

   aec_char_class u_class (
      .ch         (in_char),
      .is_digit   (is_digit),
      .is_lpar    (is_lpar),
      .is_rpar    (is_rpar),
      .is_op      (is_op),
      .is_eq      (is_eq),
      .is_space   (is_space),
      .is_illegal (is_illegal)
   );

`ifdef AEC_FEEDER_SPACE_SKIP_EN
   assign sp_en = 1'b1;
`else
   assign sp_en = 1'b0;
`endif

   assign in_ready = (state_q == ST_COLLECT) && !rst;
   assign acc      = in_valid && in_ready;
   assign skip     = is_space && sp_en;
   assign storable = is_digit || is_lpar || is_rpar ||
                     is_op || is_eq;
   assign e_ill    = is_illegal && !skip;
   // Last slot is reserved for '='
   assign e_ovf    = storable && !is_eq && (wptr_q == LAST);
   assign e_rpar   = is_rpar && (depth_q == 4'd0);
   assign wr_en    = acc && storable && !e_ovf && !e_rpar;
   assign rnext    = rptr_q + PW'(1);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr_q] <= in_char;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         wptr_q    <= '0;
         rptr_q    <= '0;
         len_q     <= '0;
         depth_q   <= 4'd0;
         ascii_out <= 8'h00;
         ready_out <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         ascii_out <= 8'h00;
         ready_out <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         unique case (state_q)
            ST_COLLECT: begin
               if (acc) begin
                  if (e_ill) begin
                     err      <= 1'b1;
                     err_code <= ERR_ILLEGAL;
                     wptr_q   <= '0;
                     depth_q  <= 4'd0;
                  end else if (skip) begin
                     // dropped without storing
                  end else if (e_ovf) begin
                     err      <= 1'b1;
                     err_code <= ERR_OVERFLOW;
                     wptr_q   <= '0;
                     depth_q  <= 4'd0;
                  end else if (e_rpar) begin
                     err      <= 1'b1;
                     err_code <= ERR_PAREN;
                     wptr_q   <= '0;
                     depth_q  <= 4'd0;
                  end else if (is_eq && (depth_q != 4'd0)) begin
                     err      <= 1'b1;
                     err_code <= ERR_PAREN;
                     wptr_q   <= '0;
                     depth_q  <= 4'd0;
                  end else begin
                     wptr_q <= wptr_q + PW'(1);
                     if (is_lpar)
                        depth_q <= depth_q + 4'd1;
                     if (is_rpar)
                        depth_q <= depth_q - 4'd1;
                     if (is_eq)
                        state_q <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               // Preload the first character so it appears on
               // the first SEND cycle.
               len_q     <= wptr_q;
               rptr_q    <= '0;
               ascii_out <= mem[0];
               ready_out <= 1'b1;
               state_q   <= ST_SEND;
            end
            ST_SEND: begin
               rptr_q <= rnext;
               if (rptr_q == len_q - PW'(1))
                  state_q <= ST_WAIT;
               else
                  ascii_out <= mem[rnext];
            end
            ST_WAIT: begin
               if (calc_valid) begin
                  wptr_q  <= '0;
                  depth_q <= 4'd0;
                  state_q <= ST_COLLECT;
               end
            end
            default: state_q <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_aec_feeder.sv
// Directed self-checking bench for aec_feeder.
// Honours AEC_FEEDER_SPACE_SKIP_EN for the space scenario.
module tb_aec_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic       in_ready;
   logic [7:0] ascii_out;
   logic       ready_out;
   logic       calc_valid = 1'b0;
   logic       err;
   logic [1:0] err_code;

   int passed = 0;
   int total  = 0;

   logic [7:0] cap_ch  [16];
   logic       cap_rdy [16];

   always #5 clk = ~clk;

   aec_feeder #(.MAX_LEN(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_char    (in_char),
      .in_ready   (in_ready),
      .ascii_out  (ascii_out),
      .ready_out  (ready_out),
      .calc_valid (calc_valid),
      .err        (err),
      .err_code   (err_code)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input string s);
      int n;
      for (int i = 0; i < s.len(); i++) begin
         in_valid = 1'b1;
         in_char  = s[i];
         n = 0;
         while (!in_ready && n < 50) begin
            tick();
            n++;
         end
         if (!in_ready) begin
            total++;
            $display("FAIL feed_timeout char %h in_ready stuck 0", s[i]);
         end
         tick();
      end
      in_valid = 1'b0;
      in_char  = 8'h00;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         cap_ch[i]  = ascii_out;
         cap_rdy[i] = ready_out;
      end
   endtask

   task automatic pulse_calc();
      calc_valid = 1'b1;
      tick();
      calc_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_char = 8'h31;
      repeat (3) tick();
      total++;
      if (in_ready !== 1'b0)
         $display("FAIL rst_in_ready got %b want 0", in_ready);
      else passed++;
      total++;
      if (ascii_out !== 8'h00 || ready_out !== 1'b0)
         $display("FAIL rst_out got %h/%b want 00/0", ascii_out, ready_out);
      else passed++;
      total++;
      if (err !== 1'b0 || err_code !== 2'd0)
         $display("FAIL rst_err got %b/%0d want 0/0", err, err_code);
      else passed++;
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1)
         $display("FAIL rel_in_ready got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_basic();
      string e;
      e = "1+2*3=";
      feed(e);
      capture(6);
      for (int i = 0; i < 6; i++) begin
         total++;
         if (cap_ch[i] !== e[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL basic_ch%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], e[i], (i == 0));
         else passed++;
      end
      tick();
      total++;
      if (ascii_out !== 8'h00 || in_ready !== 1'b0)
         $display("FAIL basic_wait got %h/%b want 00/0", ascii_out, in_ready);
      else passed++;
      pulse_calc();
      total++;
      if (in_ready !== 1'b1)
         $display("FAIL basic_resume got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_back_to_back();
      string e;
      string f;
      e = "(a-3)*2=";
      f = "7-1=";
      feed(e);
      capture(8);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (cap_ch[i] !== e[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL b2b_ch%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], e[i], (i == 0));
         else passed++;
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (in_ready !== 1'b0)
            $display("FAIL b2b_wait%0d got %b want 0", i, in_ready);
         else passed++;
      end
      pulse_calc();
      total++;
      if (in_ready !== 1'b1)
         $display("FAIL b2b_resume got %b want 1", in_ready);
      else passed++;
      feed(f);
      capture(4);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (cap_ch[i] !== f[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL b2b2_ch%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], f[i], (i == 0));
         else passed++;
      end
      tick();
      pulse_calc();
   endtask

   task automatic test_illegal();
      string e;
      feed("1+g");
      total++;
      if (err !== 1'b1 || err_code !== 2'd1)
         $display("FAIL ill_err got %b/%0d want 1/1", err, err_code);
      else passed++;
      tick();
      total++;
      if (err !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL ill_pulse got err %b rdy %b want 0/1", err, in_ready);
      else passed++;
      e = "4=";
      feed(e);
      capture(2);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (cap_ch[i] !== e[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL ill_rec%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], e[i], (i == 0));
         else passed++;
      end
      tick();
      pulse_calc();
   endtask

   task automatic test_errors();
      string e;
      feed("12345678901234");
      total++;
      if (err !== 1'b0)
         $display("FAIL ovf_early got err %b want 0", err);
      else passed++;
      feed("5");
      total++;
      if (err !== 1'b1 || err_code !== 2'd2)
         $display("FAIL ovf_err got %b/%0d want 1/2", err, err_code);
      else passed++;
      feed("(1+2=");
      total++;
      if (err !== 1'b1 || err_code !== 2'd3 || in_ready !== 1'b1)
         $display("FAIL open_par got %b/%0d rdy %b want 1/3/1",
                  err, err_code, in_ready);
      else passed++;
      tick();
      tick();
      total++;
      if (ready_out !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL open_nosend got rdy_out %b in_rdy %b want 0/1",
                  ready_out, in_ready);
      else passed++;
      feed(")");
      total++;
      if (err !== 1'b1 || err_code !== 2'd3)
         $display("FAIL close_par got %b/%0d want 1/3", err, err_code);
      else passed++;
      e = "1=";
      feed(e);
      capture(2);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (cap_ch[i] !== e[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL close_rec%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], e[i], (i == 0));
         else passed++;
      end
      tick();
      pulse_calc();
   endtask

   task automatic test_space();
`ifdef AEC_FEEDER_SPACE_SKIP_EN
      string e;
      e = "1+2=";
      feed("1 + 2=");
      capture(4);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (cap_ch[i] !== e[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL sp_ch%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], e[i], (i == 0));
         else passed++;
      end
      tick();
      pulse_calc();
`else
      feed("1 ");
      total++;
      if (err !== 1'b1 || err_code !== 2'd1)
         $display("FAIL sp_err got %b/%0d want 1/1", err, err_code);
      else passed++;
      tick();
`endif
   endtask

   task automatic test_reset_mid_send();
      string e;
      feed("9*9=");
      capture(2);
      total++;
      if (cap_ch[0] !== 8'h39 || cap_rdy[0] !== 1'b1 ||
          cap_ch[1] !== 8'h2A || cap_rdy[1] !== 1'b0)
         $display("FAIL mid_pre got %h/%b %h/%b want 39/1 2a/0",
                  cap_ch[0], cap_rdy[0], cap_ch[1], cap_rdy[1]);
      else passed++;
      rst = 1'b1;
      tick();
      total++;
      if (ascii_out !== 8'h00 || ready_out !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL mid_rst got %h/%b rdy %b want 00/0/0",
                  ascii_out, ready_out, in_ready);
      else passed++;
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1 || ascii_out !== 8'h00)
         $display("FAIL mid_idle got rdy %b out %h want 1/00",
                  in_ready, ascii_out);
      else passed++;
      e = "2=";
      feed(e);
      capture(2);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (cap_ch[i] !== e[i] || cap_rdy[i] !== (i == 0))
            $display("FAIL mid_rec%0d got %h/%b want %h/%b",
                     i, cap_ch[i], cap_rdy[i], e[i], (i == 0));
         else passed++;
      end
      tick();
      pulse_calc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_illegal();
      test_errors();
      test_space();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
